// File: rtl/bcd_serial_add_ctrl_if.sv
// Operand/result handshake bundle for the serial BCD adder.
// Producer/consumer side is master, the adder is slave.
interface bcd_serial_add_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;
  logic                  busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, err, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, err, busy
  );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit BCD adder: one shared digit adder, LSD first,
// carry rippled through a register, result on valid/ready.
module bcd_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] raw;
  logic [4:0] adj;

  assign raw  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
  assign adj  = raw - 5'd10;
  assign cout = (raw > 5'd9);
  assign s    = cout ? adj[3:0] : raw[3:0];
endmodule

module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_serial_add_ctrl_if.slave  bus
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int W  = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [W-1:0]    sum_r;
  logic            cout_r;
  logic            err_r;
  logic            ov_r;
  logic            busy_r;

  logic [3:0]      da;
  logic [3:0]      db;
  logic [3:0]      ds;
  logic            dc;
  logic            bad;
  logic            last;

  assign da   = a_r[4*idx +: 4];
  assign db   = b_r[4*idx +: 4];
  assign last = (idx == IW'(DIGITS - 1));

  bcd_adder u_digit (
    .a    (da),
    .b    (db),
    .cin  (carry),
    .s    (ds),
    .cout (dc)
  );

  // Flag any non-BCD nibble on the operands being offered
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.a[4*i +: 4] > 4'd9 || bus.b[4*i +: 4] > 4'd9)
        bad = 1'b1;
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = ov_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.err       = err_r;
  assign bus.busy      = busy_r;

  // Control FSM: accept, one digit per cycle, hold result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      err_r  <= 1'b0;
      ov_r   <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r    <= bus.a;
            b_r    <= bus.b;
            sum_r  <= '0;
            cout_r <= 1'b0;
            idx    <= '0;
            if (bad) begin
              err_r <= 1'b1;
              state <= DONE;
            end else begin
              err_r  <= 1'b0;
              carry  <= bus.cin;
              busy_r <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          sum_r[4*idx +: 4] <= ds;
          carry             <= dc;
          if (last) begin
            cout_r <= dc;
            busy_r <= 1'b0;
            ov_r   <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // Error path enters with ov_r low; raise it one cycle later
          if (!ov_r) begin
            ov_r <= 1'b1;
          end else if (bus.out_ready) begin
            ov_r  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for the serial BCD adder: random ops against a decimal
// model, scoreboard monitor, reset abort and a 1-digit sweep.
module tb_bcd_serial_add_ctrl;
  localparam int D = 4;

  typedef struct {
    logic [4*D-1:0] sum;
    logic           cout;
    logic           err;
    int             lat;
    int             acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic hold = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_serial_add_ctrl_if #(.DIGITS(D)) bus ();
  bcd_serial_add_ctrl_if #(.DIGITS(1)) bus1 ();

  bcd_serial_add_ctrl #(.DIGITS(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bcd_serial_add_ctrl #(.DIGITS(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t",
               name, act, req, $time);
    end
  endtask

  // Decimal reference: operands as integers, plain arithmetic
  function automatic exp_t model(input logic [4*D-1:0] a,
                                 input logic [4*D-1:0] b,
                                 input logic cin);
    exp_t e;
    int av, bv, pw, tot, da, db;
    logic bad;
    av = 0; bv = 0; pw = 1; bad = 1'b0;
    for (int i = 0; i < D; i++) begin
      da = int'(a[4*i +: 4]);
      db = int'(b[4*i +: 4]);
      if (da > 9 || db > 9) bad = 1'b1;
      av += da * pw;
      bv += db * pw;
      pw *= 10;
    end
    e.sum = '0;
    e.acc = 0;
    if (bad) begin
      e.cout = 1'b0;
      e.err  = 1'b1;
      e.lat  = 1;
    end else begin
      tot    = av + bv + int'(cin);
      e.cout = (tot >= pw);
      tot    = tot % pw;
      for (int i = 0; i < D; i++) begin
        e.sum[4*i +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
      e.err = 1'b0;
      e.lat = D;
    end
    return e;
  endfunction

  function automatic logic [4*D-1:0] rnd_bcd();
    logic [4*D-1:0] v;
    for (int i = 0; i < D; i++) begin
      if ($urandom_range(0, 31) == 0)
        v[4*i +: 4] = 4'($urandom_range(10, 15));
      else
        v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  task automatic do_op(input logic [4*D-1:0] a, input logic [4*D-1:0] b,
                       input logic cin);
    exp_t e;
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    @(posedge clk); #1;
    e = model(a, b, cin);
    e.acc = cyc;
    q.push_back(e);
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    bus.cin = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  // Consumer: random backpressure unless held off
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare presented results against scoreboard head
  initial begin
    logic prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          if (!prev_ov)
            chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
          chk("sum", 32'(bus.sum), 32'(q[0].sum));
          chk("cout", 32'(bus.cout), 32'(q[0].cout));
          chk("err", 32'(bus.err), 32'(q[0].err));
          chk("in_ready_done", 32'(bus.in_ready), 32'd0);
          if (bus.out_ready) void'(q.pop_front());
        end
      end
      prev_ov = !rst && bus.out_valid;
    end
  end

  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.a = '0;
    bus1.b = '0;
    bus1.cin = 1'b0;
    bus1.out_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    do_op(16'h1234, 16'h5678, 1'b0);
    do_op(16'h9999, 16'h0000, 1'b1);
    do_op(16'h9999, 16'h9999, 1'b1);
    do_op(16'h12A4, 16'h0000, 1'b0);
    do_op(16'h0001, 16'h0009, 1'b0);

    // Backpressure in DONE with ignored in_valid pulses
    drain();
    hold = 1'b1;
    do_op(16'h4567, 16'h5432, 1'b1);
    for (int n = 0; n < 20 && !bus.out_valid; n++) @(posedge clk);
    chk("hold_reached_done", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.in_valid = i[0];
      bus.a = rnd_bcd();
      bus.b = rnd_bcd();
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    hold = 1'b0;
    drain();

    // Asynchronous reset mid-RUN at idx 2
    do_op(16'h1234, 16'h4321, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("busy_run", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    q.delete();
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_sum", 32'(bus.sum), 32'd0);
    chk("abort_cout", 32'(bus.cout), 32'd0);
    chk("abort_err", 32'(bus.err), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h0808, 16'h0707, 1'b1);

    for (int i = 0; i < 40; i++)
      do_op(rnd_bcd(), rnd_bcd(), 1'($urandom));
    drain();

    // Exhaustive single-digit sweep
    for (int a = 0; a < 10; a++) begin
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < 2; c++) begin
          int n;
          n = 0;
          @(posedge clk); #1;
          while (!bus1.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
          end
          bus1.in_valid = 1'b1;
          bus1.a = 4'(a);
          bus1.b = 4'(b);
          bus1.cin = 1'(c);
          @(posedge clk); #1;
          bus1.in_valid = 1'b0;
          n = 0;
          @(negedge clk);
          while (!bus1.out_valid && n < 20) begin
            @(negedge clk);
            n++;
          end
          chk("sweep", 32'(10 * int'(bus1.cout) + int'(bus1.sum)),
              32'(a + b + c));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
